alarm_ring_ctrl: RTL and testbench

- Sequences the watch's alarm ring: detects the clock time reaching the alarm time, drives a pulsed buzzer pattern, and handles snooze, alarm-off and auto-timeout.
- Sits between the Clock and Alarm time registers and the buzzer/indicator outputs.
- Consumes the debounced, one-cycle-pulsed aoff and snooze buttons.
- Acts as the single arbiter of who may silence or re-trigger the buzzer.

---
 rtl/alarm_ring_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm ring sequencer: match detect, beep pattern, snooze, off, timeout
//
// Purpose:
//   Watches the clock time against the alarm time. On the first cycle of a
//   match it starts ringing, pulsing the buzzer in a fixed on/off pattern.
//   A snooze silences it for SNOOZE_SECS seconds, up to MAX_SNOOZE times per
//   event. aoff or dropping en stops the event. An unattended ring stops after
//   RING_SECS seconds and raises the sticky missed flag.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_en           alarm armed (level)
//   i_sec_tick     one-cycle pulse per elapsed second
//   i_hour/i_min/i_sec    current time
//   i_ahour/i_amin        alarm time
//   i_aoff         one-cycle pulse: stop the alarm / acknowledge missed
//   i_snooze       one-cycle pulse: snooze the alarm
//   o_buzz         buzzer drive (registered)
//   o_ringing      high while ringing
//   o_snoozing     high while snoozing
//   o_snooze_cnt   snoozes used in the current event
//   o_missed       last event ended by timeout (sticky)

module alarm_ring_ctrl #(
    parameter int BEEP_ON     = 4,
    parameter int BEEP_OFF    = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_sec_tick,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_ahour,
    input  logic [5:0] i_amin,
    input  logic       i_aoff,
    input  logic       i_snooze,
    output logic       o_buzz,
    output logic       o_ringing,
    output logic       o_snoozing,
    output logic [2:0] o_snooze_cnt,
    output logic       o_missed
);

    localparam int SEC_MAX  = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int W_SEC    = $clog2(SEC_MAX + 1);
    localparam int BEEP_LEN = BEEP_ON + BEEP_OFF;
    localparam int W_BEEP   = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;

    localparam logic [W_SEC-1:0]  RING_LAST  = W_SEC'(RING_SECS - 1);
    localparam logic [W_SEC-1:0]  SNZ_LOAD   = W_SEC'(SNOOZE_SECS);
    localparam logic [W_SEC-1:0]  SNZ_ONE    = W_SEC'(1);
    localparam logic [W_BEEP-1:0] BEEP_LAST  = W_BEEP'(BEEP_LEN - 1);
    localparam logic [2:0]        SNZ_LIMIT  = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_match_q;
    logic              w_match, w_trigger;
    logic [W_SEC-1:0]  r_ring_sec, w_ring_sec_next;
    logic [W_SEC-1:0]  r_snz_left, w_snz_left_next;
    logic [W_BEEP-1:0] r_beep, w_beep_next;
    logic [2:0]        r_snooze_cnt, w_snooze_cnt_next;
    logic              r_missed, w_missed_next;
    logic              r_buzz, w_buzz_next;
    logic              r_ringing, r_snoozing;

    assign w_match   = i_en && (i_hour == i_ahour) && (i_min == i_amin) && (i_sec == 6'd0);
    // Only the first cycle of a match starts an event; a held match is inert.
    assign w_trigger = w_match && !r_match_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_match_q    <= 1'b0;
            r_ring_sec   <= '0;
            r_snz_left   <= '0;
            r_beep       <= '0;
            r_snooze_cnt <= 3'd0;
            r_missed     <= 1'b0;
            r_buzz       <= 1'b0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_match_q    <= w_match;
            r_ring_sec   <= w_ring_sec_next;
            r_snz_left   <= w_snz_left_next;
            r_beep       <= w_beep_next;
            r_snooze_cnt <= w_snooze_cnt_next;
            r_missed     <= w_missed_next;
            r_buzz       <= w_buzz_next;
            r_ringing    <= (w_state_next == ST_RING);
            r_snoozing   <= (w_state_next == ST_SNOOZE);
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_ring_sec_next   = r_ring_sec;
        w_snz_left_next   = r_snz_left;
        w_beep_next       = r_beep;
        w_snooze_cnt_next = r_snooze_cnt;
        w_missed_next     = r_missed;

        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next      = ST_RING;
                    w_ring_sec_next   = '0;
                    w_beep_next       = '0;
                    w_snooze_cnt_next = 3'd0;
                    w_missed_next     = 1'b0;
                end else if (i_aoff) begin
                    // aoff in IDLE only acknowledges a missed alarm.
                    w_missed_next = 1'b0;
                end
            end

            ST_RING: begin
                // r_beep is the pattern phase of the current cycle; advance it
                // so the registered buzz reflects the next cycle's phase.
                w_beep_next = (r_beep == BEEP_LAST) ? '0 : r_beep + 1'b1;

                if (!i_en || i_aoff) begin
                    w_state_next = ST_IDLE;
                end else if (i_snooze) begin
                    if (r_snooze_cnt < SNZ_LIMIT) begin
                        w_state_next      = ST_SNOOZE;
                        w_snooze_cnt_next = r_snooze_cnt + 3'd1;
                        w_snz_left_next   = SNZ_LOAD;
                    end else begin
                        // Snooze budget used up: the press ends the event.
                        w_state_next = ST_IDLE;
                    end
                end else if (i_sec_tick) begin
                    if (r_ring_sec == RING_LAST) begin
                        w_state_next  = ST_IDLE;
                        w_missed_next = 1'b1;
                    end else begin
                        w_ring_sec_next = r_ring_sec + 1'b1;
                    end
                end
            end

            ST_SNOOZE: begin
                if (!i_en || i_aoff) begin
                    w_state_next = ST_IDLE;
                end else if (i_sec_tick) begin
                    if (r_snz_left == SNZ_ONE) begin
                        w_state_next    = ST_RING;
                        w_ring_sec_next = '0;
                        w_beep_next     = '0;
                    end else begin
                        w_snz_left_next = r_snz_left - 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Buzz only while the next cycle is a ring cycle in an on-phase; this
        // silences the buzzer on every exit from RING and in the other states.
        w_buzz_next = (w_state_next == ST_RING) && (int'(w_beep_next) < BEEP_ON);
    end

    assign o_buzz       = r_buzz;
    assign o_ringing    = r_ringing;
    assign o_snoozing   = r_snoozing;
    assign o_snooze_cnt = r_snooze_cnt;
    assign o_missed     = r_missed;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - self-checking bench for alarm_ring_ctrl

module tb_alarm_ring_ctrl;

    localparam int BEEP_ON     = 2;
    localparam int BEEP_OFF    = 2;
    localparam int RING_SECS   = 3;
    localparam int SNOOZE_SECS = 2;
    localparam int MAX_SNOOZE  = 3;

    logic       clk = 1'b0;
    logic       reset, en, sec_tick, aoff, snooze;
    logic [5:0] hour, min, sec, ahour, amin;
    logic       buzz, ringing, snoozing, missed;
    logic [2:0] snooze_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    alarm_ring_ctrl #(
        .BEEP_ON    (BEEP_ON),
        .BEEP_OFF   (BEEP_OFF),
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_en        (en),
        .i_sec_tick  (sec_tick),
        .i_hour      (hour),
        .i_min       (min),
        .i_sec       (sec),
        .i_ahour     (ahour),
        .i_amin      (amin),
        .i_aoff      (aoff),
        .i_snooze    (snooze),
        .o_buzz      (buzz),
        .o_ringing   (ringing),
        .o_snoozing  (snoozing),
        .o_snooze_cnt(snooze_cnt),
        .o_missed    (missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: tracks elapsed cycles/seconds since each phase began.
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;
    int m_mode, m_age, m_ring_secs, m_snz_secs, m_cnt;
    bit m_missed, m_prev_match;

    task automatic model_step();
        bit match, trig;
        match = en && (hour == ahour) && (min == amin) && (sec == 0);
        trig  = match && !m_prev_match;
        if (reset) begin
            m_mode = M_IDLE; m_age = 0; m_ring_secs = 0; m_snz_secs = 0;
            m_cnt = 0; m_missed = 0; m_prev_match = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (trig) begin
                    m_mode = M_RING; m_age = 0; m_ring_secs = 0; m_cnt = 0; m_missed = 0;
                end else if (aoff) begin
                    m_missed = 0;
                end
            end
            M_RING: begin
                if (!en || aoff) m_mode = M_IDLE;
                else if (snooze) begin
                    if (m_cnt < MAX_SNOOZE) begin
                        m_mode = M_SNOOZE; m_cnt++; m_snz_secs = 0;
                    end else m_mode = M_IDLE;
                end else if (sec_tick) begin
                    m_ring_secs++;
                    if (m_ring_secs == RING_SECS) begin
                        m_mode = M_IDLE; m_missed = 1;
                    end
                end
                if (m_mode == M_RING) m_age++;
            end
            default: begin
                if (!en || aoff) m_mode = M_IDLE;
                else if (sec_tick) begin
                    m_snz_secs++;
                    if (m_snz_secs == SNOOZE_SECS) begin
                        m_mode = M_RING; m_age = 0; m_ring_secs = 0;
                    end
                end
            end
        endcase
        m_prev_match = match;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (chk_en) begin
                chk("mdl_ringing", {7'd0, ringing}, {7'd0, m_mode == M_RING});
                chk("mdl_snoozing", {7'd0, snoozing}, {7'd0, m_mode == M_SNOOZE});
                chk("mdl_buzz", {7'd0, buzz},
                    {7'd0, (m_mode == M_RING) && ((m_age % (BEEP_ON + BEEP_OFF)) < BEEP_ON)});
                chk("mdl_cnt", {5'd0, snooze_cnt}, 8'(m_cnt));
                chk("mdl_missed", {7'd0, missed}, {7'd0, m_missed});
            end
        end
    end

    task automatic step(input logic a, input logic s, input logic t);
        @(negedge clk);
        aoff = a; snooze = s; sec_tick = t;
        @(posedge clk);
        #2;
    endtask

    task automatic retrigger();
        sec = 6'd1;
        step(0, 0, 0);
        sec = 6'd0;
        step(0, 0, 0);
    endtask

    initial begin
        reset = 1; en = 1; sec_tick = 0; aoff = 0; snooze = 0;
        ahour = 6'd7; amin = 6'd30; hour = 6'd7; min = 6'd29; sec = 6'd59;
        step(0, 0, 0);
        chk_en = 1'b1;
        step(0, 0, 0);
        chk("rst_buzz", {7'd0, buzz}, 8'd0);
        chk("rst_ringing", {7'd0, ringing}, 8'd0);
        chk("rst_cnt", {5'd0, snooze_cnt}, 8'd0);
        chk("rst_missed", {7'd0, missed}, 8'd0);
        reset = 0;
        step(0, 0, 0);

        // Ring, beep pattern, alarm-off
        min = 6'd30; sec = 6'd0;
        step(0, 0, 0);
        chk("ring_on", {7'd0, ringing}, 8'd1);
        chk("beep0", {7'd0, buzz}, 8'd1);
        step(0, 0, 0); chk("beep1", {7'd0, buzz}, 8'd1);
        step(0, 0, 0); chk("beep2", {7'd0, buzz}, 8'd0);
        step(0, 0, 0); chk("beep3", {7'd0, buzz}, 8'd0);
        step(0, 0, 0); chk("beep4", {7'd0, buzz}, 8'd1);
        step(1, 0, 0);
        chk("aoff_ringing", {7'd0, ringing}, 8'd0);
        chk("aoff_buzz", {7'd0, buzz}, 8'd0);
        chk("aoff_missed", {7'd0, missed}, 8'd0);
        repeat (20) step(0, 0, 0);
        chk("held_no_retrig", {7'd0, ringing}, 8'd0);

        // Timeout
        retrigger();
        chk("to_ring", {7'd0, ringing}, 8'd1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("to_still_ring", {7'd0, ringing}, 8'd1);
        step(0, 0, 1);
        chk("to_ringing", {7'd0, ringing}, 8'd0);
        chk("to_missed", {7'd0, missed}, 8'd1);
        chk("to_buzz", {7'd0, buzz}, 8'd0);
        step(0, 0, 0);
        chk("to_missed_sticky", {7'd0, missed}, 8'd1);
        step(1, 0, 0);
        chk("ack_missed", {7'd0, missed}, 8'd0);

        // Snooze cycles up to the limit
        retrigger();
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0);
            chk("snz_on", {7'd0, snoozing}, 8'd1);
            chk("snz_cnt", {5'd0, snooze_cnt}, 8'(k));
            chk("snz_buzz", {7'd0, buzz}, 8'd0);
            step(0, 0, 1);
            chk("snz_hold", {7'd0, snoozing}, 8'd1);
            step(0, 0, 1);
            chk("rering", {7'd0, ringing}, 8'd1);
            chk("rering_buzz", {7'd0, buzz}, 8'd1);
            if (k == 1) begin
                step(0, 0, 0); chk("rering_beep1", {7'd0, buzz}, 8'd1);
                step(0, 0, 0); chk("rering_beep2", {7'd0, buzz}, 8'd0);
            end
        end
        step(0, 1, 0);
        chk("lim_ringing", {7'd0, ringing}, 8'd0);
        chk("lim_snoozing", {7'd0, snoozing}, 8'd0);
        chk("lim_cnt", {5'd0, snooze_cnt}, 8'd3);
        chk("lim_missed", {7'd0, missed}, 8'd0);

        // aoff and snooze together
        retrigger();
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 1, 0);
        chk("pri_ringing", {7'd0, ringing}, 8'd0);
        chk("pri_snoozing", {7'd0, snoozing}, 8'd0);
        chk("pri_cnt", {5'd0, snooze_cnt}, 8'd1);

        // en dropped in SNOOZE, then re-armed inside the matching second
        retrigger();
        step(0, 1, 0);
        chk("en_snz", {7'd0, snoozing}, 8'd1);
        en = 0;
        step(0, 0, 0);
        chk("endrop_snoozing", {7'd0, snoozing}, 8'd0);
        chk("endrop_ringing", {7'd0, ringing}, 8'd0);
        en = 1;
        step(0, 0, 0);
        chk("arm_trig", {7'd0, ringing}, 8'd1);
        step(1, 0, 0);

        // Reset mid-ring during a buzz-high phase
        retrigger();
        chk("pre_rst_buzz", {7'd0, buzz}, 8'd1);
        reset = 1; sec = 6'd1;
        step(0, 0, 0);
        chk("mid_rst_buzz", {7'd0, buzz}, 8'd0);
        chk("mid_rst_ringing", {7'd0, ringing}, 8'd0);
        chk("mid_rst_snoozing", {7'd0, snoozing}, 8'd0);
        reset = 0;
        step(0, 0, 0);
        sec = 6'd0;
        step(0, 0, 0);
        chk("later_trig", {7'd0, ringing}, 8'd1);
        chk("later_buzz", {7'd0, buzz}, 8'd1);
        amin = 6'd31;
        step(0, 0, 0);
        chk("atime_change", {7'd0, ringing}, 8'd1);
        step(1, 0, 0);
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
